string_reader: RTL
==================

# string_reader

Receive-side line assembler for the UART console path. Accepts bytes from the UART receiver over a valid/ready byte handshake and collects them into a NUL-padded packed line buffer until a CR or LF terminator arrives. It then presents the complete line, with length and overflow flag, to the command/SD logic. Its packing format matches the packed-line format the transmit path consumes.

## Interface
Parameters:
- MAX_CHARS, 80, line capacity in characters (1..255)
- LINE_W, 8*MAX_CHARS, packed line width (derived; not overridden)

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous active-high reset; sampled on rising clk edge
- rx_data  input  8  received byte from UART receiver
- rx_data_valid  input  1  rx_data valid this cycle
- rx_data_ready  output  1  block can accept a byte; transfer occurs when valid && ready on a clk edge
- line  output  LINE_W  packed line; char 0 at [7:0], char i at [8i+7:8i], unused bytes 0x00
- line_len  output  8  number of characters in line
- line_valid  output  1  line/line_len/line_overflow stable and complete
- line_overflow  output  1  input exceeded MAX_CHARS; line holds the first MAX_CHARS chars
- line_ack  input  1  consumer takes the line; meaningful only while line_valid=1

## Operation
State machine states:
- COLLECT (reset state): rx_data_ready=1. Each accepted byte is classified in this priority order:
  - 0x0D or 0x0A with count>0: go to DONE.
  - 0x0D or 0x0A with count=0: ignore. Empty lines and the second half of CRLF/LFCR are never delivered.
  - 0x00: dropped, because NUL is the padding byte.
  - Other byte with count<MAX_CHARS: written to byte slot [count], count+1.
  - Other byte with count=MAX_CHARS: dropped, sets the sticky overflow flag, stays in COLLECT.
- DONE: rx_data_ready=0; line_valid=1. Outputs are frozen until line_ack=1.
  - On line_ack=1: buffer cleared to all zeros, count=0, overflow=0, return to COLLECT.
- line_len always equals count. line_overflow reflects the sticky flag.
- Reset mid-line or in DONE discards all content. Buffer cleared, count 0, overflow 0, state COLLECT.
- line_ack while in COLLECT: ignored.

## Timing
- Reset values: line=0, line_len=0, line_valid=0, line_overflow=0, rx_data_ready=1 (combinational from state=COLLECT).
- Terminator accepted at edge N: line_valid=1 and rx_data_ready=0 from edge N (registered state). The terminator is the last byte accepted.
- Data byte accepted at edge N: visible in line/line_len after edge N.
- line_ack sampled high at edge M while in DONE: line_valid=0, line=0, line_len=0 and rx_data_ready=1 after edge M. The next byte can be accepted at edge M+1.
- A single-cycle line_ack is sufficient. A held line_ack does not affect COLLECT.
- rx_data_valid during DONE: no transfer (ready=0). Buffering or dropping is the upstream's concern.
- rst has priority over all other inputs on the same edge.

## Configuration
- STRING_READER_BACKSPACE_EN defined:
  - Bytes 0x08 and 0x7F are editing commands.
  - With count>0, slot [count-1] is zeroed and count decrements.
  - With count=0, the byte is ignored.
  - The overflow flag is not cleared by backspace.
- Not defined: 0x08 and 0x7F are stored as ordinary characters.

## Test plan
- Reset, send "LS\r" → after the CR edge: line[15:0]=0x534C, upper bytes 0, line_len=2, line_valid=1, line_overflow=0, rx_data_ready=0.
- Send "A\r\n" with line_ack pulsed one cycle after line_valid → one line "A" delivered (len 1); LF ignored; then line_valid=0, line=0, rx_data_ready=1.
- MAX_CHARS=4, send "ABCDEF\n" → line="ABCD" (0x44434241), line_len=4, line_overflow=1. After ack, send "X\n" → line_overflow=0.
- Hold rx_data_valid=1 with 'Z' while in DONE for 10 cycles → no byte accepted, line unchanged. After ack, 'Z' is accepted as char 0.
- Send "AB", assert rst for one cycle, then "C\r" → line="C", len 1, no residue of "AB".
- With STRING_READER_BACKSPACE_EN, send "AB\x08C\r" → line="AC", len 2. Without it → len 4, slot 2 = 0x08.

Source files
------------

// File: rtl/string_reader.sv
// UART receive line assembler: packs bytes into a NUL-padded line until CR/LF.
// Optional feature macro: STRING_READER_BACKSPACE_EN (0x08/0x7F erase last char).
module string_reader #(
    parameter int MAX_CHARS = 80,
    parameter int LINE_W    = 8 * MAX_CHARS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic [LINE_W-1:0] line,
    output logic [7:0]        line_len,
    output logic              line_valid,
    output logic              line_overflow,
    input  logic              line_ack
);

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_NUL = 8'h00;
`ifdef STRING_READER_BACKSPACE_EN
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;
`endif
    localparam logic [7:0] CAP = 8'(MAX_CHARS);

    state_t            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]        count_q, count_d;
    logic              ovf_q, ovf_d;

    logic accept;
    logic is_term;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        rx_data_ready = (state_q == COLLECT);
        accept        = rx_data_valid && rx_data_ready;
        is_term       = (rx_data == CH_CR) || (rx_data == CH_LF);

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (is_term) begin
                        // Empty lines and the second half of CRLF are swallowed here
                        if (count_q != 8'd0) begin
                            state_d = DONE;
                        end
                    end else if (rx_data == CH_NUL) begin
                        count_d = count_q;
`ifdef STRING_READER_BACKSPACE_EN
                    end else if ((rx_data == CH_BS) || (rx_data == CH_DEL)) begin
                        if (count_q != 8'd0) begin
                            for (int i = 0; i < MAX_CHARS; i++) begin
                                if (count_q == 8'(i + 1)) begin
                                    line_d[i*8 +: 8] = 8'h00;
                                end
                            end
                            count_d = count_q - 8'd1;
                        end
`endif
                    end else if (count_q < CAP) begin
                        for (int i = 0; i < MAX_CHARS; i++) begin
                            if (count_q == 8'(i)) begin
                                line_d[i*8 +: 8] = rx_data;
                            end
                        end
                        count_d = count_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (line_ack) begin
                    state_d = COLLECT;
                    line_d  = '0;
                    count_d = 8'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        line          = line_q;
        line_len      = count_q;
        line_valid    = (state_q == DONE);
        line_overflow = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            line_q  <= '0;
            count_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
